// File: rtl/branch_predictor_bht.sv
// Fetch-stage dynamic branch predictor: direct-mapped table of 2-bit saturating
// counters with a branch target buffer, looked up combinationally from PCF and
// trained one entry per cycle from the execute stage. Also keeps saturating
// counts of resolved branches and mispredictions.
//
// Ports:
//   clk, rst                       clock (rising edge), async active-high reset
//   PCF                            fetch PC to look up
//   Predict_branchF/targetF/hitF   combinational prediction for PCF
//   update_en                      execute-stage branch/jump resolved this cycle
//   PCE, takenE, jumpE, targetE    resolved instruction PC, outcome, JAL flag, taken target
//   prediction_correctE            execute stage found the prediction correct
//   branch_count, mispredict_count saturating performance counters
module branch_predictor_bht #(
  parameter int unsigned INDEX_BITS = 4,
  parameter int unsigned TAG_BITS   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] PCF,
  output logic        Predict_branchF,
  output logic [31:0] Predict_targetF,
  output logic        Predict_hitF,
  input  logic        update_en,
  input  logic [31:0] PCE,
  input  logic        takenE,
  input  logic        jumpE,
  input  logic [31:0] targetE,
  input  logic        prediction_correctE,
  output logic [31:0] branch_count,
  output logic [31:0] mispredict_count
);

  localparam int unsigned ENTRIES = 1 << INDEX_BITS;
  localparam int unsigned TAG_LO  = INDEX_BITS + 2;
  localparam int unsigned TAG_HI  = TAG_LO + TAG_BITS - 1;

  localparam logic [1:0] CTR_STRONG_T = 2'b11;
  localparam logic [1:0] CTR_WEAK_T   = 2'b10;
  localparam logic [1:0] CTR_WEAK_NT  = 2'b01;
  localparam logic [1:0] CTR_STRONG_NT = 2'b00;

  logic                valid   [ENTRIES];
  logic [TAG_BITS-1:0] tags    [ENTRIES];
  logic [1:0]          ctrs    [ENTRIES];
  logic [31:0]         targets [ENTRIES];

  logic [INDEX_BITS-1:0] idx_f;
  logic [TAG_BITS-1:0]   tag_f;
  logic                  hit_f;
  logic [INDEX_BITS-1:0] idx_e;
  logic [TAG_BITS-1:0]   tag_e;
  logic                  hit_e;
  logic [1:0]            ctr_e;
  logic [1:0]            ctr_inc;
  logic [1:0]            ctr_dec;
  logic                  unused_pc_bits;

  // Byte offset and PC bits above the tag do not take part in indexing.
  assign unused_pc_bits = ^{PCF[1:0], PCF[31:TAG_HI+1], PCE[1:0], PCE[31:TAG_HI+1]};

  // Fetch lookup: zero latency, reads the table as it stands this cycle.
  assign idx_f           = PCF[INDEX_BITS+1:2];
  assign tag_f           = PCF[TAG_HI:TAG_LO];
  assign hit_f           = valid[idx_f] && (tags[idx_f] == tag_f);
  assign Predict_hitF    = hit_f;
  assign Predict_branchF = hit_f & ctrs[idx_f][1];
  assign Predict_targetF = hit_f ? targets[idx_f] : 32'h0;

  // Execute-side lookup for training.
  assign idx_e   = PCE[INDEX_BITS+1:2];
  assign tag_e   = PCE[TAG_HI:TAG_LO];
  assign hit_e   = valid[idx_e] && (tags[idx_e] == tag_e);
  assign ctr_e   = ctrs[idx_e];
  assign ctr_inc = (ctr_e == CTR_STRONG_T)  ? CTR_STRONG_T  : 2'(ctr_e + 2'd1);
  assign ctr_dec = (ctr_e == CTR_STRONG_NT) ? CTR_STRONG_NT : 2'(ctr_e - 2'd1);

  // Table training; a not-taken miss never allocates, a taken miss replaces the entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(ENTRIES); i++) begin
        valid[i]   <= 1'b0;
        tags[i]    <= '0;
        ctrs[i]    <= CTR_WEAK_NT;
        targets[i] <= 32'h0;
      end
    end else if (update_en) begin
      if (hit_e) begin
        if (jumpE) begin
          ctrs[idx_e]    <= CTR_STRONG_T;
          targets[idx_e] <= targetE;
        end else if (takenE) begin
          ctrs[idx_e]    <= ctr_inc;
          targets[idx_e] <= targetE;
        end else begin
          ctrs[idx_e]    <= ctr_dec;
        end
      end else if (takenE) begin
        valid[idx_e]   <= 1'b1;
        tags[idx_e]    <= tag_e;
        targets[idx_e] <= targetE;
        ctrs[idx_e]    <= jumpE ? CTR_STRONG_T : CTR_WEAK_T;
      end
    end
  end

  // Saturating performance counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      branch_count     <= 32'h0;
      mispredict_count <= 32'h0;
    end else if (update_en) begin
      if (branch_count != 32'hFFFF_FFFF) begin
        branch_count <= branch_count + 32'd1;
      end
      if (!prediction_correctE && (mispredict_count != 32'hFFFF_FFFF)) begin
        mispredict_count <= mispredict_count + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_branch_predictor_bht.sv
// Self-checking bench for branch_predictor_bht: a table of directed vectors
// (inputs plus hand-computed pre-update lookup and counter values), followed by
// hand-written sequences for counter saturation and asynchronous reset.
module tb_branch_predictor_bht;

  logic        clk;
  logic        rst;
  logic [31:0] PCF;
  logic        Predict_branchF;
  logic [31:0] Predict_targetF;
  logic        Predict_hitF;
  logic        update_en;
  logic [31:0] PCE;
  logic        takenE;
  logic        jumpE;
  logic [31:0] targetE;
  logic        prediction_correctE;
  logic [31:0] branch_count;
  logic [31:0] mispredict_count;

  int checks = 0;
  int errors = 0;

  branch_predictor_bht #(.INDEX_BITS(4), .TAG_BITS(8)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .PCF                 (PCF),
    .Predict_branchF     (Predict_branchF),
    .Predict_targetF     (Predict_targetF),
    .Predict_hitF        (Predict_hitF),
    .update_en           (update_en),
    .PCE                 (PCE),
    .takenE              (takenE),
    .jumpE               (jumpE),
    .targetE             (targetE),
    .prediction_correctE (prediction_correctE),
    .branch_count        (branch_count),
    .mispredict_count    (mispredict_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        upd;
    logic [31:0] pce;
    logic        taken;
    logic        jump;
    logic [31:0] tgt;
    logic        corr;
    logic [31:0] pcf;
    logic        exp_hit;
    logic        exp_br;
    logic [31:0] exp_tgt;
    logic [31:0] exp_bc;
    logic [31:0] exp_mc;
  } vec_t;

  localparam int NVEC = 24;
  vec_t vecs [NVEC];

  function automatic vec_t mk(logic upd, logic [31:0] pce, logic taken, logic jump,
                              logic [31:0] tgt, logic corr, logic [31:0] pcf,
                              logic exp_hit, logic exp_br, logic [31:0] exp_tgt,
                              logic [31:0] exp_bc, logic [31:0] exp_mc);
    vec_t v;
    v.upd = upd; v.pce = pce; v.taken = taken; v.jump = jump; v.tgt = tgt; v.corr = corr;
    v.pcf = pcf; v.exp_hit = exp_hit; v.exp_br = exp_br; v.exp_tgt = exp_tgt;
    v.exp_bc = exp_bc; v.exp_mc = exp_mc;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic hit, input logic br,
                           input logic [31:0] tgt, input logic [31:0] bc, input logic [31:0] mc);
    check({tag, " hit"},    32'(Predict_hitF), 32'(hit));
    check({tag, " branch"}, 32'(Predict_branchF), 32'(br));
    check({tag, " target"}, Predict_targetF, tgt);
    check({tag, " bcount"}, branch_count, bc);
    check({tag, " mcount"}, mispredict_count, mc);
  endtask

  task automatic drive(input logic upd, input logic [31:0] pce, input logic taken,
                       input logic jump, input logic [31:0] tgt, input logic corr,
                       input logic [31:0] pcf);
    update_en = upd; PCE = pce; takenE = taken; jumpE = jump; targetE = tgt;
    prediction_correctE = corr; PCF = pcf;
  endtask

  initial begin
    // Index = PC[5:2], tag = PC[13:6]; 0x40, 0x100, 0x140, 0x200 all share index 0.
    // Expected values are the lookup/counters before that cycle's update commits.
    vecs[0]  = mk(0, 32'h40,  0, 0, 32'h0,  1, 32'h40,  0, 0, 32'h0,  0,  0);
    vecs[1]  = mk(1, 32'h40,  1, 0, 32'h80, 0, 32'h40,  0, 0, 32'h0,  0,  0);
    vecs[2]  = mk(0, 32'h40,  0, 0, 32'h0,  1, 32'h40,  1, 1, 32'h80, 1,  1);
    vecs[3]  = mk(1, 32'h40,  0, 0, 32'h0,  0, 32'h40,  1, 1, 32'h80, 1,  1);
    vecs[4]  = mk(1, 32'h40,  0, 0, 32'h0,  1, 32'h40,  1, 0, 32'h80, 2,  2);
    vecs[5]  = mk(1, 32'h40,  0, 0, 32'h0,  1, 32'h40,  1, 0, 32'h80, 3,  2);
    vecs[6]  = mk(1, 32'h40,  1, 0, 32'h88, 1, 32'h40,  1, 0, 32'h80, 4,  2);
    vecs[7]  = mk(1, 32'h40,  1, 0, 32'h88, 0, 32'h40,  1, 0, 32'h88, 5,  2);
    vecs[8]  = mk(0, 32'h40,  0, 0, 32'h0,  1, 32'h40,  1, 1, 32'h88, 6,  3);
    vecs[9]  = mk(1, 32'h200, 0, 0, 32'h0,  1, 32'h44,  0, 0, 32'h0,  6,  3);
    vecs[10] = mk(0, 32'h200, 1, 0, 32'h90, 0, 32'h200, 0, 0, 32'h0,  7,  3);
    vecs[11] = mk(1, 32'h100, 1, 1, 32'h20, 1, 32'h40,  1, 1, 32'h88, 7,  3);
    vecs[12] = mk(0, 32'h0,   0, 0, 32'h0,  1, 32'h100, 1, 1, 32'h20, 8,  3);
    vecs[13] = mk(0, 32'h0,   0, 0, 32'h0,  1, 32'h40,  0, 0, 32'h0,  8,  3);
    vecs[14] = mk(1, 32'h140, 0, 0, 32'h0,  1, 32'h140, 0, 0, 32'h0,  8,  3);
    vecs[15] = mk(1, 32'h100, 0, 0, 32'h0,  1, 32'h100, 1, 1, 32'h20, 9,  3);
    vecs[16] = mk(1, 32'h100, 0, 0, 32'h0,  1, 32'h100, 1, 1, 32'h20, 10, 3);
    vecs[17] = mk(1, 32'h100, 1, 1, 32'h24, 1, 32'h100, 1, 0, 32'h20, 11, 3);
    vecs[18] = mk(1, 32'h100, 0, 0, 32'h0,  1, 32'h100, 1, 1, 32'h24, 12, 3);
    vecs[19] = mk(1, 32'h140, 1, 0, 32'h30, 0, 32'h100, 1, 1, 32'h24, 13, 3);
    vecs[20] = mk(0, 32'h0,   0, 0, 32'h0,  1, 32'h140, 1, 1, 32'h30, 14, 4);
    vecs[21] = mk(0, 32'h0,   0, 0, 32'h0,  1, 32'h100, 0, 0, 32'h0,  14, 4);
    vecs[22] = mk(1, 32'h3C,  1, 0, 32'hABCD_0000, 1, 32'h3F, 0, 0, 32'h0, 14, 4);
    vecs[23] = mk(0, 32'h0,   0, 0, 32'h0,  1, 32'h3F,  1, 1, 32'hABCD_0000, 15, 4);

    drive(0, 32'h0, 0, 0, 32'h0, 1, 32'h40);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_all("reset", 0, 0, 32'h0, 32'h0, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk);
      drive(vecs[i].upd, vecs[i].pce, vecs[i].taken, vecs[i].jump, vecs[i].tgt,
            vecs[i].corr, vecs[i].pcf);
      #1;
      check_all($sformatf("vec%0d", i), vecs[i].exp_hit, vecs[i].exp_br, vecs[i].exp_tgt,
                vecs[i].exp_bc, vecs[i].exp_mc);
    end

    // Saturation: preload counters near the top, then keep resolving mispredicts.
    @(negedge clk);
    drive(0, 32'h0, 0, 0, 32'h0, 1, 32'h3F);
    force dut.branch_count = 32'hFFFF_FFFE;
    force dut.mispredict_count = 32'hFFFF_FFFF;
    #1;
    release dut.branch_count;
    release dut.mispredict_count;
    @(negedge clk);
    check("preload bcount", branch_count, 32'hFFFF_FFFE);
    check("preload mcount", mispredict_count, 32'hFFFF_FFFF);
    drive(1, 32'h3C, 0, 0, 32'h0, 0, 32'h3F);
    @(negedge clk);
    check("sat1 bcount", branch_count, 32'hFFFF_FFFF);
    check("sat1 mcount", mispredict_count, 32'hFFFF_FFFF);
    @(negedge clk);
    check("sat2 bcount", branch_count, 32'hFFFF_FFFF);
    check("sat2 mcount", mispredict_count, 32'hFFFF_FFFF);
    // Entry 0x3C: was 10, two not-taken updates take it to 00.
    drive(0, 32'h0, 0, 0, 32'h0, 1, 32'h3C);
    #1;
    check_all("sat hold", 1, 0, 32'hABCD_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

    // Asynchronous reset mid-cycle with an update in flight across the edge.
    @(negedge clk);
    drive(1, 32'h3C, 1, 1, 32'h1234_5678, 0, 32'h3C);
    #1;
    rst = 1'b1;
    #1;
    check_all("async rst", 0, 0, 32'h0, 32'h0, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    drive(0, 32'h0, 0, 0, 32'h0, 1, 32'h3C);
    #1;
    check_all("post rst", 0, 0, 32'h0, 32'h0, 32'h0);
    @(negedge clk);
    drive(0, 32'h0, 0, 0, 32'h0, 1, 32'h100);
    #1;
    check_all("post rst 0x100", 0, 0, 32'h0, 32'h0, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
